// File: rtl/sdram_timing_unit.sv
// Timing counter beside the SDRAM control FSM: turns load strobes into a countdown
// with decoded status, and schedules periodic auto-refresh windows.
module sdram_timing_unit #(
    parameter int CW       = 10,
    parameter int TPRE     = 3,
    parameter int TCAS     = 3,
    parameter int TRFC     = 7,
    parameter int TREF_INT = 780
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_tpre,
    input  logic          load_tcas,
    input  logic          load_tburst,
    input  logic          load_twait,
    input  logic [3:0]    burst,
    input  logic [1:0]    size,
    input  logic [9:0]    tlat,
    output logic [CW-1:0] countout,
    output logic [1:0]    status,
    output logic          ref_done,
    output logic          load_err,
    output logic          ref_overrun
);

    localparam int RW = $clog2(TREF_INT + 1);
    localparam logic [RW-1:0] REF_RELOAD = RW'(TREF_INT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        REFRESH = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    status_q, status_d;
    logic          ref_done_q, ref_done_d;
    logic          load_err_q, load_err_d;
    logic          ref_overrun_q, ref_overrun_d;
    logic          ref_pending_q, ref_pending_d;
    logic [RW-1:0] ref_cnt_q, ref_cnt_d;

    logic          any_load;
    logic          multi_load;
    logic          ref_tick;
    logic          ref_clear;
    logic [CW-1:0] load_n;

    function automatic logic [CW-1:0] at_least_one(input logic [CW-1:0] v);
        return (v == '0) ? CW'(1) : v;
    endfunction

    // Priority tpre > tcas > tburst > twait; a zero-length load becomes one cycle.
    function automatic logic [CW-1:0] load_value(
        input logic       lp,
        input logic       lc,
        input logic       lb,
        input logic [3:0] b,
        input logic [1:0] s,
        input logic [9:0] t
    );
        logic [3:0]    beff;
        logic [6:0]    prod;
        logic [CW-1:0] v;
        beff = (b == 4'd0) ? 4'd1 : b;
        prod = {3'b000, beff} << s;
        if (lp)      v = CW'(TPRE);
        else if (lc) v = CW'(TCAS);
        else if (lb) v = CW'(prod);
        else         v = CW'(t);
        return at_least_one(v);
    endfunction

    function automatic logic [1:0] decode_status(input state_t st, input logic [CW-1:0] c);
        logic [1:0] r;
        case (st)
            REFRESH: r = 2'b11;
            COUNT:   r = (c == CW'(1)) ? 2'b10 : ((c == '0) ? 2'b00 : 2'b01);
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    always_comb begin
        any_load   = load_tpre | load_tcas | load_tburst | load_twait;
        multi_load = $countones({load_tpre, load_tcas, load_tburst, load_twait}) > 1;
        load_n     = load_value(load_tpre, load_tcas, load_tburst, burst, size, tlat);

        state_d    = state_q;
        cnt_d      = cnt_q;
        ref_done_d = 1'b0;
        ref_clear  = 1'b0;
        ref_tick   = (ref_cnt_q == '0);
        ref_cnt_d  = ref_tick ? REF_RELOAD : (ref_cnt_q - RW'(1));

        load_err_d    = load_err_q | multi_load | (any_load && state_q == REFRESH);
        ref_overrun_d = ref_overrun_q | (ref_tick & ref_pending_q);

        case (state_q)
            IDLE: begin
                if (any_load) begin
                    state_d = COUNT;
                    cnt_d   = load_n;
                end else if (ref_pending_q) begin
                    state_d = REFRESH;
                    cnt_d   = CW'(TRFC);
                end
            end
            COUNT: begin
                if (any_load) begin
                    cnt_d = load_n;
                end else if (cnt_q <= CW'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            REFRESH: begin
                if (cnt_q <= CW'(1)) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    ref_done_d = 1'b1;
                    ref_clear  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A fresh interval expiry outranks the clear from a finishing window.
        if (ref_tick)       ref_pending_d = 1'b1;
        else if (ref_clear) ref_pending_d = 1'b0;
        else                ref_pending_d = ref_pending_q;

        status_d = decode_status(state_d, cnt_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            status_q      <= 2'b00;
            ref_done_q    <= 1'b0;
            load_err_q    <= 1'b0;
            ref_overrun_q <= 1'b0;
            ref_pending_q <= 1'b0;
            ref_cnt_q     <= REF_RELOAD;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            status_q      <= status_d;
            ref_done_q    <= ref_done_d;
            load_err_q    <= load_err_d;
            ref_overrun_q <= ref_overrun_d;
            ref_pending_q <= ref_pending_d;
            ref_cnt_q     <= ref_cnt_d;
        end
    end

    assign countout    = cnt_q;
    assign status      = status_q;
    assign ref_done    = ref_done_q;
    assign load_err    = load_err_q;
    assign ref_overrun = ref_overrun_q;

endmodule

// File: tb/tb_sdram_timing_unit.sv
// Bench for sdram_timing_unit: directed literal checks plus randomized loads/resets
// compared every cycle against a cycle-count based behavioural model.
module tb_sdram_timing_unit;

    localparam int CW       = 10;
    localparam int TPRE     = 3;
    localparam int TCAS     = 3;
    localparam int TRFC     = 7;
    localparam int TREF_INT = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load_tpre = 1'b0, load_tcas = 1'b0, load_tburst = 1'b0, load_twait = 1'b0;
    logic [3:0]    burst = '0;
    logic [1:0]    size = '0;
    logic [9:0]    tlat = '0;
    logic [CW-1:0] countout;
    logic [1:0]    status;
    logic          ref_done, load_err, ref_overrun;

    sdram_timing_unit #(
        .CW(CW), .TPRE(TPRE), .TCAS(TCAS), .TRFC(TRFC), .TREF_INT(TREF_INT)
    ) dut (
        .clk(clk), .reset(reset),
        .load_tpre(load_tpre), .load_tcas(load_tcas),
        .load_tburst(load_tburst), .load_twait(load_twait),
        .burst(burst), .size(size), .tlat(tlat),
        .countout(countout), .status(status), .ref_done(ref_done),
        .load_err(load_err), .ref_overrun(ref_overrun)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    // Model: remaining cycles, refresh flag, and a cycle index since reset from
    // which refresh requests fall out as multiples of TREF_INT.
    int m_rem, m_t;
    bit m_refr, m_pend, m_err, m_ovr, m_done;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int m_status();
        if (m_refr)      return 3;
        if (m_rem == 0)  return 0;
        if (m_rem == 1)  return 2;
        return 1;
    endfunction

    task automatic model_step();
        int  nl, nv;
        bit  req, clr, pend_old;
        nl = int'(load_tpre) + int'(load_tcas) + int'(load_tburst) + int'(load_twait);
        if (reset) begin
            m_rem = 0; m_t = 0; m_refr = 0; m_pend = 0;
            m_err = 0; m_ovr = 0; m_done = 0;
            return;
        end
        if (load_tpre)        nv = TPRE;
        else if (load_tcas)   nv = TCAS;
        else if (load_tburst) nv = ((burst == 0) ? 1 : int'(burst)) * (1 << size);
        else                  nv = (tlat == 0) ? 1 : int'(tlat);
        m_t++;
        req = (m_t % TREF_INT) == 0;
        clr = 0;
        m_done = 0;
        if (nl > 1 || (nl > 0 && m_refr)) m_err = 1;
        if (m_refr) begin
            if (m_rem == 1) begin
                m_rem = 0; m_refr = 0; m_done = 1; clr = 1;
            end else m_rem--;
        end else if (nl > 0) m_rem = nv;
        else if (m_rem > 0)  m_rem--;
        else if (m_pend) begin
            m_refr = 1; m_rem = TRFC;
        end
        pend_old = m_pend;
        if (req && pend_old) m_ovr = 1;
        if (req)      m_pend = 1;
        else if (clr) m_pend = 0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("countout", int'(countout), m_rem);
            chk("status", int'(status), m_status());
            chk("ref_done", int'(ref_done), int'(m_done));
            chk("load_err", int'(load_err), int'(m_err));
            chk("ref_overrun", int'(ref_overrun), int'(m_ovr));
        end
    end

    // One clock: model advances at the edge, bench resumes just after the compare.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_loads();
        load_tpre = 0; load_tcas = 0; load_tburst = 0; load_twait = 0;
    endtask

    task automatic do_reset();
        clear_loads();
        reset = 1;
        step();
        reset = 0;
    endtask

    initial begin
        #2;
        do_reset();
        chk_en = 1'b1;
        chk("reset_countout", int'(countout), 0);
        chk("reset_status", int'(status), 0);
        chk("reset_load_err", int'(load_err), 0);

        // TCAS countdown 3,2,1,0 with status 01,01,10,00
        load_tcas = 1; step(); clear_loads();
        chk("tcas_c3", int'(countout), 3); chk("tcas_s3", int'(status), 1);
        step(); chk("tcas_c2", int'(countout), 2); chk("tcas_s2", int'(status), 1);
        step(); chk("tcas_c1", int'(countout), 1); chk("tcas_s1", int'(status), 2);
        step(); chk("tcas_c0", int'(countout), 0); chk("tcas_s0", int'(status), 0);
        chk("tcas_err", int'(load_err), 0);

        // burst 4 x 4 words = 16 cycles, last-cycle status on the 16th
        do_reset();
        burst = 4; size = 2; load_tburst = 1; step(); clear_loads();
        chk("burst_c16", int'(countout), 16);
        for (int i = 2; i <= 16; i++) step();
        chk("burst_s16", int'(status), 2);
        step(); chk("burst_end", int'(status), 0);

        // zero burst and zero tlat both become one cycle
        do_reset();
        burst = 0; size = 0; load_tburst = 1; step(); clear_loads();
        chk("b0_c", int'(countout), 1); chk("b0_s", int'(status), 2);
        step(); chk("b0_idle", int'(status), 0);
        tlat = 0; load_twait = 1; step(); clear_loads();
        chk("t0_c", int'(countout), 1); chk("t0_s", int'(status), 2);
        step(); chk("t0_idle", int'(status), 0);

        // simultaneous loads: tpre wins, sticky error
        do_reset();
        tlat = 9; load_tpre = 1; load_twait = 1; step(); clear_loads();
        chk("multi_c", int'(countout), TPRE); chk("multi_err", int'(load_err), 1);
        for (int i = 0; i < 5; i++) step();
        chk("multi_sticky", int'(load_err), 1);

        // idle refresh window at cycle 21, with a load ignored inside it
        do_reset();
        for (int t = 1; t <= 29; t++) begin
            if (t == 23) load_tcas = 1;
            step();
            clear_loads();
            if (t == 20) chk("ref_pre", int'(status), 0);
            if (t == 21) chk("ref_c7", int'(countout), TRFC);
            if (t >= 21 && t <= 27) chk("ref_s11", int'(status), 3);
            if (t == 23) chk("ref_ld_err", int'(load_err), 1);
            if (t == 24) chk("ref_c4", int'(countout), 4);
            if (t == 28) begin
                chk("ref_done", int'(ref_done), 1); chk("ref_s00", int'(status), 0);
            end
            if (t == 29) chk("ref_done_pulse", int'(ref_done), 0);
        end

        // reset in the middle of a refresh window restarts the interval
        do_reset();
        for (int t = 1; t <= 23; t++) step();
        chk("mid_ref_s", int'(status), 3);
        reset = 1; step(); reset = 0;
        chk("rst_ref_c", int'(countout), 0); chk("rst_ref_s", int'(status), 0);
        chk("rst_ref_done", int'(ref_done), 0);
        for (int t = 1; t <= 21; t++) begin
            step();
            if (t == 20) chk("rst_ref_pre", int'(status), 0);
            if (t == 21) chk("rst_ref_again", int'(status), 3);
        end

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            clear_loads();
            reset = ($urandom_range(0, 299) == 0);
            burst = 4'($urandom_range(0, 15));
            size  = 2'($urandom_range(0, 3));
            tlat  = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(1, 40));
            if ($urandom_range(0, 31) == 0) begin
                load_tpre = 1'($urandom); load_tcas = 1'($urandom);
                load_tburst = 1'($urandom); load_twait = 1'($urandom);
            end else if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 3))
                    0: load_tpre = 1;
                    1: load_tcas = 1;
                    2: load_tburst = 1;
                    default: load_twait = 1;
                endcase
            end
            step();
        end
        reset = 0;
        clear_loads();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
